// File: rtl/mem_bus_adapter.sv
// ============================================================================
// Module   : mem_bus_adapter
// Brief    : Valid/ready request bus to single-port memory bridge with byte
//            strobe read-modify-write. Optional address range check enabled
//            by defining MEM_BUS_ERR_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_bus_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_SIZE  = 1024
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    req_valid_in,
  output logic                    req_ready_out,
  input  logic                    req_write_in,
  input  logic [DATA_WIDTH-1:0]   req_addr_in,
  input  logic [DATA_WIDTH-1:0]   req_wdata_in,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_in,
  output logic                    rsp_valid_out,
  input  logic                    rsp_ready_in,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_out,
  output logic                    rsp_err_out,
  output logic                    mem_enable_out,
  output logic                    mem_read_write_out,
  output logic [DATA_WIDTH-1:0]   mem_addr_out,
  output logic [DATA_WIDTH-1:0]   mem_data_out,
  input  logic [DATA_WIDTH-1:0]   mem_data_in
);

  localparam int c_strb_w   = DATA_WIDTH / 8;
  localparam int c_off_bits = $clog2(c_strb_w);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_live;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [c_strb_w-1:0]     r_wstrb;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [DATA_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_data;
  logic [DATA_WIDTH-1:0]   w_word_addr;
  logic [DATA_WIDTH-1:0]   w_merged;
  logic                    w_hs;
  logic                    w_addr_err;

  assign w_word_addr = req_addr_in >> c_off_bits;
  // r_live keeps req_ready low while reset is held and for the release edge.
  assign w_hs        = req_valid_in && r_live && (r_state == ST_IDLE);

`ifdef MEM_BUS_ERR_EN
  localparam logic [DATA_WIDTH-1:0] c_data_size = DATA_WIDTH'(DATA_SIZE);
  logic r_err;

  assign w_addr_err = (w_word_addr >= c_data_size);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_err <= 1'b0;
    end else if (w_hs) begin
      r_err <= w_addr_err;
    end
  end

  assign rsp_err_out = r_err;
`else
  assign w_addr_err  = 1'b0;
  assign rsp_err_out = 1'b0;
`endif

  generate
    for (genvar i = 0; i < c_strb_w; i++) begin : g_merge
      assign w_merged[8*i +: 8] = r_wstrb[i] ? r_wdata[8*i +: 8] : mem_data_in[8*i +: 8];
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          if (w_addr_err)            w_next_state = ST_RESP;
          else if (!req_write_in)    w_next_state = ST_READ;
          else if (~|req_wstrb_in)   w_next_state = ST_RESP;
          else if (&req_wstrb_in)    w_next_state = ST_WRITE;
          else                       w_next_state = ST_READ;
        end
      end
      ST_READ:    w_next_state = ST_RD_WAIT;
      ST_RD_WAIT: w_next_state = r_write ? ST_WRITE : ST_RESP;
      ST_WRITE:   w_next_state = ST_RESP;
      ST_RESP:    if (rsp_ready_in) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rdata    <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      if (w_hs) begin
        r_write <= req_write_in;
        r_wdata <= req_wdata_in;
        r_wstrb <= req_wstrb_in;
        r_rdata <= '0;
        // mem_addr/mem_data only move when an access is actually launched
        if (w_next_state == ST_READ || w_next_state == ST_WRITE) begin
          r_mem_addr <= w_word_addr;
        end
        if (w_next_state == ST_WRITE) begin
          r_mem_data <= req_wdata_in;
        end
      end
      if (r_state == ST_RD_WAIT) begin
        if (r_write) r_mem_data <= w_merged;
        else         r_rdata    <= mem_data_in;
      end
    end
  end

  assign req_ready_out      = r_live && (r_state == ST_IDLE);
  assign rsp_valid_out      = (r_state == ST_RESP);
  assign rsp_rdata_out      = r_rdata;
  assign mem_enable_out     = (r_state == ST_READ) || (r_state == ST_WRITE);
  assign mem_read_write_out = (r_state == ST_WRITE);
  assign mem_addr_out       = r_mem_addr;
  assign mem_data_out       = r_mem_data;

endmodule

`default_nettype wire
